systolic_result_reader: RTL
===========================

SYSTOLIC_RESULT_READER -- requirements
Module: systolic_result_reader

Interface
REQ-001 SHALL have parameter PEROW, default 9: number of PE rows in the result grid.
REQ-002 SHALL have parameter PECOL, default 9: number of PE columns in the result grid.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 27: wait cycles after start before the first read (range 1..255).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-005 SHALL have port areset, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: request to drain the array; sampled only in IDLE.
REQ-007 SHALL have port rd_address, output, 8 bits: array read address; [7:4] = row, [3:0] = column.
REQ-008 SHALL have port rd_data, input, 32 bits: array result at rd_address, combinational from the array.
REQ-009 SHALL have port m_data, output, 32 bits: streamed result word.
REQ-010 SHALL have port m_valid, output, 1 bit: m_data valid.
REQ-011 SHALL have port m_ready, input, 1 bit: downstream accepts when m_valid and m_ready are both high.
REQ-012 SHALL have port m_last, output, 1 bit: marks the final word of a drain.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse after the final handshake.

Function
REQ-015 SHALL implement the states IDLE, SETTLE, LOAD, STREAM.
REQ-016 IDLE: when start=1, SHALL clear the settle counter, set rd_address=8'h00 and go to SETTLE; otherwise stay in IDLE.
REQ-017 SETTLE: SHALL count exactly SETTLE_CYCLES cycles in SETTLE, then go to LOAD.
REQ-018 LOAD (one cycle): SHALL register rd_data into m_data, set m_valid=1 on the next edge, set m_last if the address is the final one, and go to STREAM.
REQ-019 STREAM: SHALL hold m_data, m_valid and m_last stable while m_ready=0.
REQ-020 STREAM on handshake, not last: SHALL drop m_valid, advance the address and go to LOAD.
REQ-021 STREAM on handshake, last: SHALL drop m_valid and m_last, pulse done for one cycle, return to IDLE and set rd_address=8'h00.
REQ-022 SHALL sustain a throughput of one word per 2 cycles with m_ready held high.
REQ-023 Default address order SHALL be row-major: column 0..PECOL-1, then wrap the column to 0 and increment the row; final address = {PEROW-1, PECOL-1}.
REQ-024 SHALL produce exactly PEROW*PECOL handshakes per drain (81 at default parameters).
REQ-025 SHALL ignore start in SETTLE, LOAD and STREAM (no restart, no queuing).
REQ-026 SHALL NOT modify the result value; m_data SHALL be bit-exact with rd_data.
REQ-027 SHALL drive m_valid=0 and m_last=0 in IDLE and SETTLE.
REQ-028 If start=1 in the same cycle done pulses, SHALL ignore that start, because the FSM is leaving STREAM.

Reset
REQ-029 areset=1 SHALL immediately force: state IDLE, rd_address=8'h00, m_data=0, m_valid=0, m_last=0, done=0, counters=0; busy=0 follows from IDLE.
REQ-030 Reset mid-drain SHALL abandon the drain with no done pulse; the first start after release SHALL begin again at address 8'h00.
REQ-031 Release of areset SHALL take effect on the next clk edge; no spurious m_valid SHALL follow release.

Configuration
REQ-032 With macro RESULT_TRANSPOSE_EN defined, address order SHALL be column-major: row 0..PEROW-1, then wrap the row to 0 and increment the column; final address = {PEROW-1, PECOL-1}; word count unchanged.
REQ-033 Without RESULT_TRANSPOSE_EN, SHALL use the row-major order of REQ-023; no other behaviour differs.

Verification
REQ-034 Stub rd_data={24'h0,rd_address}, m_ready=1, one start pulse -> busy rises; first m_valid exactly SETTLE_CYCLES+2 cycles after start; 81 words 0x00,0x01..0x08,0x10..0x88; m_last on 0x88 only; done one cycle later.
REQ-035 Random m_ready stalls (about 50%) -> m_data/m_last stable during stalls; same 81-word sequence; no drops or duplicates.
REQ-036 start pulsed during SETTLE and again during STREAM -> no effect; exactly 81 words, one done pulse.
REQ-037 areset asserted after the 40th handshake -> outputs zero immediately; next start streams from 0x00 with 81 words.
REQ-038 RESULT_TRANSPOSE_EN defined, same stub -> order 0x00,0x10..0x80,0x01..0x88; m_last on 0x88.
REQ-039 start held high during the done cycle -> FSM returns to IDLE; a new drain starts on the following cycle only.

Source files
------------

// File: rtl/systolic_result_reader.sv
// ---------------------------------------------------------------------------
// systolic_result_reader
//
// Drains the result grid of a PEROW x PECOL systolic array after a compute
// pass. Once started, it waits SETTLE_CYCLES cycles for the array outputs to
// become stable. It then walks every PE address and streams each 32-bit
// result over a valid/ready interface. Each word takes one LOAD cycle (the
// array read) and at least one STREAM cycle (the handshake). With m_ready
// held high this gives one word every two cycles.
//
// Address order is row-major (column fastest) by default. Define
// RESULT_TRANSPOSE_EN to walk column-major (row fastest) instead. Both orders
// end on {PEROW-1, PECOL-1} and produce PEROW*PECOL words.
//
// Ports
//   clk        : clock, all state on the rising edge
//   areset     : asynchronous active-high reset
//   start      : request a drain; only acted on in IDLE
//   rd_address : array read address, [7:4] = row, [3:0] = column
//   rd_data    : array result at rd_address (combinational from the array)
//   m_data     : streamed result word
//   m_valid    : m_data valid
//   m_ready    : downstream ready; a transfer happens when valid & ready
//   m_last     : marks the final word of a drain
//   busy       : high whenever the FSM is not IDLE
//   done       : one-cycle pulse after the final handshake
// ---------------------------------------------------------------------------
module systolic_result_reader #(
    parameter int PEROW         = 9,
    parameter int PECOL         = 9,
    parameter int SETTLE_CYCLES = 27
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        start,
    output logic [7:0]  rd_address,
    input  logic [31:0] rd_data,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOAD   = 2'd2,
        STREAM = 2'd3
    } state_t;

    localparam logic [3:0] ROW_LAST    = 4'(PEROW - 1);
    localparam logic [3:0] COL_LAST    = 4'(PECOL - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic [3:0]  row_q,   row_d;
    logic [3:0]  col_q,   col_d;
    logic [31:0] data_q,  data_d;
    logic        valid_q, valid_d;
    logic        last_q,  last_d;
    logic        done_q,  done_d;
    logic        at_final;

    assign at_final   = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign rd_address = {row_q, col_q};
    assign m_data     = data_q;
    assign m_valid    = valid_q;
    assign m_last     = last_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // In the done cycle the drain has only just ended. A start
                // seen then belongs to the drain that is finishing, so it is
                // ignored. A start still high one cycle later begins a new
                // drain.
                if (start && !done_q) begin
                    cnt_d   = 8'd0;
                    row_d   = 4'd0;
                    col_d   = 4'd0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            LOAD: begin
                data_d  = rd_data;
                valid_d = 1'b1;
                last_d  = at_final;
                state_d = STREAM;
            end
            STREAM: begin
                if (valid_q && m_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        done_d  = 1'b1;
                        row_d   = 4'd0;
                        col_d   = 4'd0;
                        state_d = IDLE;
                    end else begin
`ifdef RESULT_TRANSPOSE_EN
                        if (row_q == ROW_LAST) begin
                            row_d = 4'd0;
                            col_d = col_q + 4'd1;
                        end else begin
                            row_d = row_q + 4'd1;
                        end
`else
                        if (col_q == COL_LAST) begin
                            col_d = 4'd0;
                            row_d = row_q + 4'd1;
                        end else begin
                            col_d = col_q + 4'd1;
                        end
`endif
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            row_q   <= 4'd0;
            col_q   <= 4'd0;
            data_q  <= 32'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

endmodule
